// File: rtl/prime_serial_sequencer.sv
// Serial front end for the 8-bit prime detector: clears the external mod-n
// checkers, shifts the candidate in MSB-first and turns their flags into a verdict.
module prime_serial_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter logic [4:0]  CHECK_MASK = 5'b11111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              div3,
  input  logic              div5,
  input  logic              div7,
  input  logic              div11,
  input  logic              div13,
  output logic              chk_clr,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              busy,
  output logic              done,
  output logic              is_prime
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              chk_clr_q, chk_clr_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_bit_q, ser_bit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              is_prime_q, is_prime_d;
  logic [4:0]        flags;
  logic              verdict;

  assign flags = {div13, div11, div7, div5, div3} & CHECK_MASK;

  // Small primes are their own checker's multiple, so they bypass the flags.
  always_comb begin
    verdict = 1'b0;
    if (data_q < DATA_W'(2)) begin
      verdict = 1'b0;
    end else if (data_q inside {DATA_W'(2), DATA_W'(3), DATA_W'(5),
                                DATA_W'(7), DATA_W'(11), DATA_W'(13)}) begin
      verdict = 1'b1;
    end else if (!data_q[0]) begin
      verdict = 1'b0;
    end else begin
      verdict = (flags == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    is_prime_d = is_prime_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_CLR;
          data_d     = data;
          is_prime_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        state_d = S_SHIFT;
        cnt_d   = CNT_W'(DATA_W - 1);
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        state_d    = S_DONE;
        is_prime_d = verdict;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are flops loaded from the next-state decode so they align with the state.
    chk_clr_d   = (state_d == S_CLR);
    ser_valid_d = (state_d == S_SHIFT);
    ser_bit_d   = (state_d == S_SHIFT) ? data_q[cnt_d] : 1'b0;
    busy_d      = (state_d == S_CLR) || (state_d == S_SHIFT) || (state_d == S_SAMPLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      chk_clr_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      is_prime_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      chk_clr_q   <= chk_clr_d;
      ser_valid_q <= ser_valid_d;
      ser_bit_q   <= ser_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      is_prime_q  <= is_prime_d;
    end
  end

  assign chk_clr   = chk_clr_q;
  assign ser_valid = ser_valid_q;
  assign ser_bit   = ser_bit_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign is_prime  = is_prime_q;

endmodule

// File: tb/tb_prime_serial_sequencer.sv
// Bench for prime_serial_sequencer: two instances (default mask, 13 masked) driven
// in lockstep, each with its own behavioural mod-n checker models.
module tb_prime_serial_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;

  logic [1:0] chk_clr, ser_valid, ser_bit, busy, done, is_prime;
  logic [4:0] flag [2];
  int unsigned res [2][5] = '{default: 0};
  int unsigned pr [5] = '{3, 5, 7, 11, 13};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prime_serial_sequencer #(.DATA_W(8), .CHECK_MASK(5'b11111)) dut0 (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .div3(flag[0][0]), .div5(flag[0][1]), .div7(flag[0][2]),
    .div11(flag[0][3]), .div13(flag[0][4]),
    .chk_clr(chk_clr[0]), .ser_valid(ser_valid[0]), .ser_bit(ser_bit[0]),
    .busy(busy[0]), .done(done[0]), .is_prime(is_prime[0])
  );

  prime_serial_sequencer #(.DATA_W(8), .CHECK_MASK(5'b01111)) dut1 (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .div3(flag[1][0]), .div5(flag[1][1]), .div7(flag[1][2]),
    .div11(flag[1][3]), .div13(flag[1][4]),
    .chk_clr(chk_clr[1]), .ser_valid(ser_valid[1]), .ser_bit(ser_bit[1]),
    .busy(busy[1]), .done(done[1]), .is_prime(is_prime[1])
  );

  // Residue checkers: r := 0 on clear, r := (2r + bit) mod n on a valid bit.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 5; j++) begin
        if (chk_clr[i]) res[i][j] <= 0;
        else if (ser_valid[i]) res[i][j] <= (2 * res[i][j] + ser_bit[i]) % pr[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flag[i] = '0;
      for (int j = 0; j < 5; j++) flag[i][j] = (res[i][j] == 0);
    end
  end

  function automatic bit true_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit rule_prime(input int n, input logic [4:0] mask);
    if (n < 2) return 1'b0;
    if (n == 2 || n == 3 || n == 5 || n == 7 || n == 11 || n == 13) return 1'b1;
    if (n % 2 == 0) return 1'b0;
    for (int j = 0; j < 5; j++) if (mask[j] && (n % pr[j] == 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; start is raised at once so the next rising edge accepts.
  task automatic run_one(input logic [7:0] d, input bit hold, input bit glitch);
    logic [1:0] expv;
    expv  = {rule_prime(int'(d), 5'b01111), true_prime(int'(d))};
    start = 1'b1;
    data  = d;
    @(negedge clk);
    if (!hold) start = 1'b0;
    data = 8'($urandom);
    chk("clr_cycle", {chk_clr, ser_valid, busy}, {2'b11, 2'b00, 2'b11});
    chk("prime_cleared", is_prime, 2'b00);
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      chk("shift_cycle", {chk_clr, ser_valid, ser_bit, busy}, {2'b00, 2'b11, {2{d[9-k]}}, 2'b11});
      data = 8'($urandom);
      if (glitch && k == 5) start = 1'b1;
      else if (!hold) start = 1'b0;
    end
    @(negedge clk);
    chk("sample_cycle", {ser_valid, busy, done}, {2'b00, 2'b11, 2'b00});
    @(negedge clk);
    chk("done_cycle", {done, busy, chk_clr}, {2'b11, 2'b00, 2'b00});
    chk("verdict", is_prime, expv);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       exp;
    logic       exp_m;
  } vec_t;

  vec_t tbl [10];
  bit   seen;

  initial begin
    tbl = '{
      '{8'd0,   1'b0, 1'b0}, '{8'd1,   1'b0, 1'b0}, '{8'd2,   1'b1, 1'b1},
      '{8'd3,   1'b1, 1'b1}, '{8'd13,  1'b1, 1'b1}, '{8'd251, 1'b1, 1'b1},
      '{8'd97,  1'b1, 1'b1}, '{8'd91,  1'b0, 1'b0}, '{8'd169, 1'b0, 1'b1},
      '{8'd255, 1'b0, 1'b0}
    };

    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {chk_clr, ser_valid, ser_bit, busy, done, is_prime}, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {chk_clr, ser_valid, busy, done}, '0);

    foreach (tbl[i]) begin
      run_one(tbl[i].d, 1'b0, 1'b0);
      chk("table_verdict", is_prime, {tbl[i].exp_m, tbl[i].exp});
      @(negedge clk);
      chk("idle_hold", {busy, done, is_prime}, {4'b0000, tbl[i].exp_m, tbl[i].exp});
    end

    // Start held high: three results back to back, 11 cycles apart.
    run_one(8'd7, 1'b1, 1'b0);
    run_one(8'd221, 1'b1, 1'b0);
    run_one(8'd211, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("throughput_idle", {busy, done}, '0);

    run_one(8'd169, 1'b0, 1'b1);
    @(negedge clk);
    chk("glitch_idle", {busy, done}, '0);

    // Asynchronous reset in cycle 5 aborts the sequence.
    start = 1'b1;
    data  = 8'd97;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_outputs", {chk_clr, ser_valid, ser_bit, busy, done, is_prime}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done != 2'b00 || busy != 2'b00) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_one(8'd211, 1'b0, 1'b0);

    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        start = 1'b0;
        @(negedge clk);
      end
      run_one(8'($urandom_range(0, 255)), 1'b0, bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 256; n++) run_one(8'(n), 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prime_serial_sequencer.md
Name: prime_serial_sequencer

Overview:
- Transmit end of the serial divisibility-checker interface.
- Accepts an 8-bit candidate on a start strobe and clears the external mod-n residue checkers (3, 5, 7, 11, 13).
- Shifts the candidate into the checkers MSB-first, one bit per clock, then samples their divN flags.
- Combines the flags with an internal div-2 test and small-prime exceptions to produce a registered prime verdict for the 8-bit prime detector.

Parameters:
- DATA_W, 8, candidate width; only 8 is supported (trial divisors up to 13 cover all n < 256).
- CHECK_MASK, 5'b11111, enable per flag {div13,div11,div7,div5,div3}; a disabled flag is treated as 0.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE or DONE
- data  input  8  candidate, captured on the accepting edge
- div3  input  1  checker flag, residue mod 3 == 0
- div5  input  1  checker flag, residue mod 5 == 0
- div7  input  1  checker flag, residue mod 7 == 0
- div11  input  1  checker flag, residue mod 11 == 0
- div13  input  1  checker flag, residue mod 13 == 0
- chk_clr  output  1  synchronous clear to checkers (residue := 0)
- ser_valid  output  1  ser_bit is valid this cycle
- ser_bit  output  1  serial candidate bit, MSB first
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion pulse
- is_prime  output  1  verdict, held until the next accepted start

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - chk_clr, ser_valid, ser_bit, busy, done and is_prime are all 0.
  - Shift register and bit counter are cleared.
  - Reset asserted mid-sequence aborts it immediately; no done pulse is produced.
- Checker contract:
  - A checker updates r := (2r + ser_bit) mod n on each rising edge where ser_valid=1.
  - It sets r := 0 on an edge where chk_clr=1.
  - Its divN flag is combinational from r.
- All outputs are registered state decodes.
- Cycle k counts from the edge that accepts start (k=0):
  - k=1, CLR: chk_clr=1, busy=1.
  - k=2..9, SHIFT: ser_valid=1, ser_bit=data_latched[9-k]; the 3-bit counter counts 7 down to 0.
  - k=10, SAMPLE: ser_valid=0, busy=1. The flags reflect all 8 bits, and the edge ending this cycle captures them.
  - k=11, DONE: done=1, busy=0, is_prime valid.
  - Next state is IDLE, or CLR if start=1 in DONE.
- Back-to-back operation: start held high gives one result every 11 cycles.
- start in CLR, SHIFT or SAMPLE is ignored. The data input is don't-care after the accepting edge.
- Verdict, computed from data_latched n and the sampled flags f = {div13..div3} & CHECK_MASK:
  - n < 2: not prime.
  - n in {2, 3, 5, 7, 11, 13}: prime (its own flag is ignored).
  - else n[0]==0: not prime.
  - else: prime iff f == 0.
- is_prime updates only on the edge entering DONE.
- is_prime is cleared to 0 on the accepting edge of a new start.
- Edge values: n=0 gives flags all 1 and is not prime. n=1 gives all flags 0 but is still not prime.

Test Plan:
- The bench models the checkers with the contract above.
- data=97, start pulse:
  - ser_bit sequence 0,1,1,0,0,0,0,1 in cycles 2-9; chk_clr only in cycle 1.
  - done in cycle 11 with is_prime=1.
- data=91 -> div7=div13=1 at SAMPLE -> is_prime=0. data=169 -> div13 -> 0. data=255 -> div3, div5 -> 0.
- Small-value rule: data=0, 1, 2, 3, 13, 251 -> is_prime = 0, 0, 1, 1, 1, 1.
- Throughput and start filtering:
  - start held high over 3 candidates (7, 221, 211) -> done every 11 cycles, verdicts 1, 0, 1.
  - start pulsed during SHIFT -> ignored.
- reset=0 in cycle 5 of a sequence -> all outputs 0 asynchronously, no done; a new start after release completes normally.
- CHECK_MASK=5'b01111, data=169 -> is_prime=1 (div13 masked); exhaustive sweep 0..255 with default mask -> matches the prime table.
